// File: rtl/clock_text_writer.sv
// Draws the "HH:MM" clock text into the character VRAM at a fixed position,
// redrawing only when the digits or the blinking colon change.
module clock_text_writer #(
  parameter int ROW    = 0,
  parameter int COL    = 75,
  parameter int COLS   = 80,
  parameter int ADDR_W = 12
) (
  input  logic              CLOCK_50,
  input  logic              clrn,
  input  logic [31:0]       ascii,
  input  logic              tick_1hz,
  input  logic              blink_en,
  input  logic              vram_ready,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_data,
  output logic              busy
);

  localparam int                BASE_I = ROW * COLS + COL;
  localparam logic [ADDR_W-1:0] BASE   = BASE_I[ADDR_W-1:0];

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Character shown at screen offset idx of the five-character field.
  function automatic logic [7:0] char_at(input logic [2:0]  idx,
                                         input logic [31:0] digits,
                                         input logic [7:0]  colon);
    logic [7:0] chr;
    case (idx)
      3'd0:    chr = digits[31:24];
      3'd1:    chr = digits[23:16];
      3'd2:    chr = colon;
      3'd3:    chr = digits[15:8];
      3'd4:    chr = digits[7:0];
      default: chr = 8'h20;
    endcase
    return chr;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [31:0]       s1_r, s2_r;
  logic              colon_on_r;
  logic [31:0]       shown_ascii_r, shown_ascii_nxt_s;
  logic [7:0]        shown_colon_r, shown_colon_nxt_s;
  logic              refresh_pending_r, refresh_pending_nxt_s;
  logic [2:0]        idx_r, idx_nxt_s, idx_inc_s;
  logic              we_r, we_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [7:0]        data_r, data_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              stable_s, dirty_s;
  logic [7:0]        colon_chr_s;

  // Two-stage capture of the ascii bus coming from the slower clock.
  always_ff @(posedge CLOCK_50 or negedge clrn) begin
    if (!clrn) begin
      s1_r <= 32'h0000_0000;
      s2_r <= 32'h0000_0000;
    end else begin
      s1_r <= ascii;
      s2_r <= s1_r;
    end
  end

  // Colon blink phase, flipped once per second.
  always_ff @(posedge CLOCK_50 or negedge clrn) begin
    if (!clrn) begin
      colon_on_r <= 1'b1;
    end else if (tick_1hz) begin
      colon_on_r <= ~colon_on_r;
    end else begin
      colon_on_r <= colon_on_r;
    end
  end

  assign stable_s    = (s1_r == s2_r);
  assign colon_chr_s = (!blink_en || colon_on_r) ? 8'h3A : 8'h20;
  assign dirty_s     = stable_s && (refresh_pending_r ||
                                    (s2_r != shown_ascii_r) ||
                                    (colon_chr_s != shown_colon_r));
  assign idx_inc_s   = idx_r + 3'd1;

  // Next-state, snapshot and next-output logic of the redraw FSM.
  always_comb begin
    state_nxt_s           = state_r;
    shown_ascii_nxt_s     = shown_ascii_r;
    shown_colon_nxt_s     = shown_colon_r;
    refresh_pending_nxt_s = refresh_pending_r;
    idx_nxt_s             = idx_r;
    we_nxt_s              = we_r;
    addr_nxt_s            = addr_r;
    data_nxt_s            = data_r;
    busy_nxt_s            = busy_r;
    case (state_r)
      IDLE: begin
        if (dirty_s) begin
          state_nxt_s           = WRITE;
          shown_ascii_nxt_s     = s2_r;
          shown_colon_nxt_s     = colon_chr_s;
          refresh_pending_nxt_s = 1'b0;
          idx_nxt_s             = 3'd0;
          we_nxt_s              = 1'b1;
          busy_nxt_s            = 1'b1;
          addr_nxt_s            = BASE;
          data_nxt_s            = s2_r[31:24];
        end else begin
          we_nxt_s   = 1'b0;
          busy_nxt_s = 1'b0;
        end
      end
      WRITE: begin
        if (we_r && vram_ready) begin
          if (idx_r == 3'd4) begin
            state_nxt_s = IDLE;
            we_nxt_s    = 1'b0;
            busy_nxt_s  = 1'b0;
          end else begin
            idx_nxt_s  = idx_inc_s;
            addr_nxt_s = BASE + {{(ADDR_W-3){1'b0}}, idx_inc_s};
            data_nxt_s = char_at(idx_inc_s, shown_ascii_r, shown_colon_r);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        we_nxt_s    = 1'b0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // FSM state, snapshot and registered write-port outputs.
  always_ff @(posedge CLOCK_50 or negedge clrn) begin
    if (!clrn) begin
      state_r           <= IDLE;
      shown_ascii_r     <= 32'h0000_0000;
      shown_colon_r     <= 8'h00;
      refresh_pending_r <= 1'b1;
      idx_r             <= 3'd0;
      we_r              <= 1'b0;
      addr_r            <= {ADDR_W{1'b0}};
      data_r            <= 8'h00;
      busy_r            <= 1'b0;
    end else begin
      state_r           <= state_nxt_s;
      shown_ascii_r     <= shown_ascii_nxt_s;
      shown_colon_r     <= shown_colon_nxt_s;
      refresh_pending_r <= refresh_pending_nxt_s;
      idx_r             <= idx_nxt_s;
      we_r              <= we_nxt_s;
      addr_r            <= addr_nxt_s;
      data_r            <= data_nxt_s;
      busy_r            <= busy_nxt_s;
    end
  end

  assign vram_we   = we_r;
  assign vram_addr = addr_r;
  assign vram_data = data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_clock_text_writer.sv
// Scoreboard bench for clock_text_writer: a pass-level reference model queues
// the expected VRAM writes and a monitor checks every accepted write.
module tb_clock_text_writer;

  localparam int ROW    = 0;
  localparam int COL    = 75;
  localparam int COLS   = 80;
  localparam int ADDR_W = 12;
  localparam int BASE   = ROW * COLS + COL;

  logic              CLOCK_50 = 1'b0;
  logic              clrn;
  logic [31:0]       ascii;
  logic              tick_1hz;
  logic              blink_en;
  logic              vram_ready;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_data;
  logic              busy;

  clock_text_writer #(.ROW(ROW), .COL(COL), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .CLOCK_50  (CLOCK_50),
    .clrn      (clrn),
    .ascii     (ascii),
    .tick_1hz  (tick_1hz),
    .blink_en  (blink_en),
    .vram_ready(vram_ready),
    .vram_we   (vram_we),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .busy      (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: ascii as seen one and two edges ago, screen contents
  // last drawn, count of writes still owed in the current pass.
  logic [31:0] seen1, seen2;
  logic [31:0] m_shown;
  logic [7:0]  m_shown_colon;
  logic [7:0]  m_cc;
  logic [39:0] m_line;
  bit          m_pending;
  int          m_ticks;
  int          m_left;
  wr_t         m_ent;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_digits();
    return {8'h30 + 8'($urandom_range(0, 9)), 8'h30 + 8'($urandom_range(0, 9)),
            8'h30 + 8'($urandom_range(0, 9)), 8'h30 + 8'($urandom_range(0, 9))};
  endfunction

  initial begin
    forever begin
      @(posedge CLOCK_50 or negedge clrn);
      if (!clrn) begin
        seen1 = 32'h0; seen2 = 32'h0; m_shown = 32'h0; m_shown_colon = 8'h0;
        m_pending = 1'b1; m_ticks = 0; m_left = 0;
        exp_q.delete();
      end else begin
        m_cc = (!blink_en || (m_ticks % 2 == 0)) ? 8'h3A : 8'h20;
        if (m_left > 0) begin
          if (vram_ready) m_left--;
        end else if (seen1 == seen2 &&
                     (m_pending || seen2 != m_shown || m_cc != m_shown_colon)) begin
          m_shown = seen2; m_shown_colon = m_cc; m_pending = 1'b0; m_left = 5;
          m_line = {seen2[31:16], m_cc, seen2[15:0]};
          for (int i = 0; i < 5; i++) begin
            m_ent.addr = ADDR_W'(BASE + i);
            m_ent.data = m_line[39 - 8*i -: 8];
            exp_q.push_back(m_ent);
          end
        end
        if (tick_1hz) m_ticks++;
        seen2 = seen1;
        seen1 = ascii;
      end
    end
  end

  // Monitor: sampled 2 time units after the falling edge.
  logic              prev_hold = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [7:0]        prev_data;
  wr_t               got;
  initial begin
    forever begin
      @(negedge CLOCK_50);
      #2;
      if (clrn) begin
        check("busy", {31'h0, busy}, {31'h0, m_left > 0});
        check("vram_we", {31'h0, vram_we}, {31'h0, m_left > 0});
        if (prev_hold && vram_we) begin
          check("hold_addr", {20'h0, vram_addr}, {20'h0, prev_addr});
          check("hold_data", {24'h0, vram_data}, {24'h0, prev_data});
        end
        if (vram_we && vram_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL write: got addr %0d data %h expected no write", vram_addr, vram_data);
          end else begin
            got = exp_q.pop_front();
            check("write_addr", {20'h0, vram_addr}, {20'h0, got.addr});
            check("write_data", {24'h0, vram_data}, {24'h0, got.data});
          end
        end
        prev_hold = vram_we && !vram_ready;
        prev_addr = vram_addr;
        prev_data = vram_data;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic wait_write(input int a);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge CLOCK_50);
      #1;
      if (vram_we && vram_addr == ADDR_W'(a)) found = 1'b1;
    end
    check("wait_write", {31'h0, found}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulse_tick();
    @(negedge CLOCK_50) tick_1hz = 1'b1;
    @(negedge CLOCK_50) tick_1hz = 1'b0;
  endtask

  initial begin
    clrn = 1'b0; ascii = 32'h3132_3539; tick_1hz = 1'b0;
    blink_en = 1'b0; vram_ready = 1'b1;
    #2;
    check("rst_we", {31'h0, vram_we}, 32'd0);
    check("rst_addr", {20'h0, vram_addr}, 32'd0);
    check("rst_data", {24'h0, vram_data}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    idle(2);
    clrn = 1'b1;
    idle(20);

    // Blink: colon off, on, off again, then blink disabled forces ':'.
    blink_en = 1'b1;
    pulse_tick(); idle(15);
    pulse_tick(); idle(15);
    pulse_tick(); idle(15);
    @(negedge CLOCK_50) blink_en = 1'b0;
    idle(15);

    // Latency from an ascii change to the first write request.
    @(negedge CLOCK_50) ascii = 32'h3133_3030;
    @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
    check("latency_e2", {31'h0, vram_we}, 32'd0);
    @(posedge CLOCK_50); #1;
    check("latency_e3", {31'h0, vram_we}, 32'd1);
    idle(15);

    // Back-pressure on the second character.
    @(negedge CLOCK_50) ascii = 32'h3133_3031;
    wait_write(BASE + 1);
    vram_ready = 1'b0;
    idle(4);
    check("stall_addr", {20'h0, vram_addr}, BASE + 1);
    vram_ready = 1'b1;
    idle(15);

    // ascii changes while the colon is being written.
    @(negedge CLOCK_50) ascii = 32'h3133_3132;
    wait_write(BASE + 2);
    ascii = 32'h3133_3235;
    idle(25);

    // Reset in the middle of a pass.
    @(negedge CLOCK_50) ascii = 32'h3133_3330;
    wait_write(BASE + 3);
    #2 clrn = 1'b0;
    #1;
    check("midrst_we", {31'h0, vram_we}, 32'd0);
    check("midrst_busy", {31'h0, busy}, 32'd0);
    @(negedge CLOCK_50) clrn = 1'b1;
    idle(25);

    // Randomised traffic.
    blink_en = 1'b1;
    repeat (1500) begin
      @(negedge CLOCK_50);
      vram_ready = ($urandom_range(0, 3) != 0);
      tick_1hz   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
      if ($urandom_range(0, 19) == 0) ascii = rand_digits();
    end
    @(negedge CLOCK_50) begin vram_ready = 1'b1; tick_1hz = 1'b0; end
    idle(40);
    check("drain_queue", exp_q.size(), 32'd0);
    check("drain_busy", {31'h0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
